// File: rtl/dds_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dds_ctrl_pkg
// Shared encodings for the DDS sequencing controller: mode codes, FSM state
// enum, DAC midscale code and waveform-configuration reset defaults.
// -----------------------------------------------------------------------------
package dds_ctrl_pkg;

    localparam logic [1:0] MODE_TONE  = 2'b00;
    localparam logic [1:0] MODE_SWEEP = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TONE  = 3'd1,
        ST_SWEEP = 3'd2,
        ST_BURST = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Code the downstream DAC path substitutes while out_en is low.
    localparam logic [13:0] DAC_MIDSCALE = 14'd8192;

    localparam logic [2:0]  WAVE_RESET   = 3'd0;
    localparam logic [4:0]  AMP_RESET    = 5'd1;
    localparam logic [13:0] PWORD_RESET  = 14'd0;

    // Run state entered from IDLE for a given mode; the reserved code runs as a tone.
    function automatic state_e mode_to_state(input logic [1:0] mode);
        state_e st;
        case (mode)
            MODE_SWEEP: st = ST_SWEEP;
            MODE_BURST: st = ST_BURST;
            default:    st = ST_TONE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/dds_cfg_shadow.sv
// -----------------------------------------------------------------------------
// dds_cfg_shadow
// Shadow register for the waveform configuration (wave select, amplitude,
// phase offset). A new configuration is accepted through a valid/ready
// handshake and only transferred to the active outputs on a phase-accumulator
// wrap (or immediately while the controller is idle), so the waveform never
// changes mid-period.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   idle_i           controller is in IDLE (apply without waiting for a wrap)
//   phase_wrap_i     phase accumulator overflow pulse
//   cfg_valid_i      configuration offered
//   cfg_wave_c_i / cfg_amplitude_i / cfg_p_word_i   offered configuration
//   cfg_ready_o      shadow register free
//   wave_c_o / amplitude_o / p_word_o               active configuration
// -----------------------------------------------------------------------------
module dds_cfg_shadow
    import dds_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idle_i,
    input  logic        phase_wrap_i,
    input  logic        cfg_valid_i,
    input  logic [2:0]  cfg_wave_c_i,
    input  logic [4:0]  cfg_amplitude_i,
    input  logic [13:0] cfg_p_word_i,
    output logic        cfg_ready_o,
    output logic [2:0]  wave_c_o,
    output logic [4:0]  amplitude_o,
    output logic [13:0] p_word_o
);

    logic [2:0]  sh_wave_q;
    logic [4:0]  sh_amp_q;
    logic [13:0] sh_pword_q;
    logic        pending_q;
    logic        applied_q;
    logic        cfg_ready_q;
    logic [2:0]  wave_q;
    logic [4:0]  amp_q;
    logic [13:0] pword_q;

    // Capture into the shadow, apply on a wrap boundary, then reopen the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_wave_q   <= WAVE_RESET;
            sh_amp_q    <= AMP_RESET;
            sh_pword_q  <= PWORD_RESET;
            pending_q   <= 1'b0;
            applied_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            wave_q      <= WAVE_RESET;
            amp_q       <= AMP_RESET;
            pword_q     <= PWORD_RESET;
        end else begin
            applied_q <= 1'b0;
            // Ready comes back one cycle after the active registers were loaded.
            if (applied_q) begin
                cfg_ready_q <= 1'b1;
            end
            if (cfg_valid_i && cfg_ready_q) begin
                sh_wave_q   <= cfg_wave_c_i;
                sh_amp_q    <= cfg_amplitude_i;
                sh_pword_q  <= cfg_p_word_i;
                pending_q   <= 1'b1;
                cfg_ready_q <= 1'b0;
            end else if (pending_q && (phase_wrap_i || idle_i)) begin
                // pending_q is only set after the capture edge, so a wrap in the
                // capture cycle itself never applies.
                wave_q    <= sh_wave_q;
                amp_q     <= sh_amp_q;
                pword_q   <= sh_pword_q;
                pending_q <= 1'b0;
                applied_q <= 1'b1;
            end
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign wave_c_o    = wave_q;
    assign amplitude_o = amp_q;
    assign p_word_o    = pword_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Sequencing controller in front of the DDS waveform datapath. Produces the
// frequency word for fixed-tone, sweep and N-cycle burst modes, gates the DAC
// output and passes waveform configuration through a wrap-synchronised shadow.
//
// Build option: DDS_SWEEP_CTRL_LOG_SWEEP_EN selects an exponential sweep
// (increment = f_word >> f_step[4:0], minimum 1) instead of the linear one.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, stop           single-cycle control pulses
//   mode                  00 tone, 01 sweep, 10 burst, 11 tone
//   f_start/f_stop/f_step sweep/tone frequency words
//   dwell                 clocks per sweep step (0 -> 1)
//   burst_cycles          periods per burst (0 -> 1)
//   phase_wrap            phase accumulator overflow pulse
//   cfg_valid/cfg_*       waveform configuration offer; cfg_ready handshake
//   f_word                frequency word to the DDS
//   wave_c/amplitude/p_word  active waveform configuration
//   out_en                DAC enable
//   busy                  controller not idle
//   done                  pulse at burst end / sweep pass complete
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int FW_W    = 32,
    parameter int DWELL_W = 32,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [FW_W-1:0]    f_start,
    input  logic [FW_W-1:0]    f_stop,
    input  logic [FW_W-1:0]    f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [BURST_W-1:0] burst_cycles,
    input  logic               phase_wrap,
    input  logic               cfg_valid,
    input  logic [2:0]         cfg_wave_c,
    input  logic [4:0]         cfg_amplitude,
    input  logic [13:0]        cfg_p_word,
    output logic               cfg_ready,
    output logic [FW_W-1:0]    f_word,
    output logic [2:0]         wave_c,
    output logic [4:0]         amplitude,
    output logic [13:0]        p_word,
    output logic               out_en,
    output logic               busy,
    output logic               done
);

    state_e             state_q;
    logic [FW_W-1:0]    f_word_q;
    logic [FW_W-1:0]    f_start_q;
    logic [FW_W-1:0]    f_stop_q;
    logic [FW_W-1:0]    f_step_q;
    logic [DWELL_W-1:0] dwell_eff_q;
    logic [DWELL_W-1:0] dwell_cnt_q;
    logic [BURST_W-1:0] burst_eff_q;
    logic [BURST_W-1:0] wrap_cnt_q;
    logic               out_en_q;
    logic               busy_q;
    logic               done_q;

    logic [FW_W-1:0]    inc_d;
    logic [FW_W:0]      sum_d;
    logic               dwell_end_d;
    logic               burst_last_d;
    logic               sweep_degen_d;
    logic               idle_s;

    // Sweep increment, carry-preserving next frequency and terminal-count decodes.
    always_comb begin
`ifdef DDS_SWEEP_CTRL_LOG_SWEEP_EN
        if ((f_word_q >> f_step_q[4:0]) == {FW_W{1'b0}}) begin
            inc_d = {{(FW_W-1){1'b0}}, 1'b1};
        end else begin
            inc_d = f_word_q >> f_step_q[4:0];
        end
`else
        inc_d = f_step_q;
`endif
        sum_d         = {1'b0, f_word_q} + {1'b0, inc_d};
        dwell_end_d   = (dwell_cnt_q == (dwell_eff_q - DWELL_W'(1)));
        burst_last_d  = (wrap_cnt_q == (burst_eff_q - BURST_W'(1)));
        // A zero step or an empty range would never reach f_stop: hold f_start.
        sweep_degen_d = (f_step_q == {FW_W{1'b0}}) || (f_start_q >= f_stop_q);
    end

    // Controller FSM with registered frequency word, enable, busy and done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            f_word_q    <= {FW_W{1'b0}};
            f_start_q   <= {FW_W{1'b0}};
            f_stop_q    <= {FW_W{1'b0}};
            f_step_q    <= {FW_W{1'b0}};
            dwell_eff_q <= {DWELL_W{1'b0}};
            dwell_cnt_q <= {DWELL_W{1'b0}};
            burst_eff_q <= {BURST_W{1'b0}};
            wrap_cnt_q  <= {BURST_W{1'b0}};
            out_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // stop is ignored here, so start+stop simply starts.
                    if (start) begin
                        f_start_q   <= f_start;
                        f_stop_q    <= f_stop;
                        f_step_q    <= f_step;
                        dwell_eff_q <= (dwell == {DWELL_W{1'b0}}) ? DWELL_W'(1) : dwell;
                        burst_eff_q <= (burst_cycles == {BURST_W{1'b0}}) ? BURST_W'(1) : burst_cycles;
                        dwell_cnt_q <= {DWELL_W{1'b0}};
                        wrap_cnt_q  <= {BURST_W{1'b0}};
                        f_word_q    <= f_start;
                        out_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= mode_to_state(mode);
                    end
                end
                ST_TONE: begin
                    if (stop) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_SWEEP: begin
                    if (stop) begin
                        state_q <= ST_DRAIN;
                    end else if (!sweep_degen_d) begin
                        if (dwell_end_d) begin
                            dwell_cnt_q <= {DWELL_W{1'b0}};
                            if (f_word_q == f_stop_q) begin
                                // Pass complete: restart from the bottom.
                                done_q   <= 1'b1;
                                f_word_q <= f_start_q;
                            end else if (sum_d >= {1'b0, f_stop_q}) begin
                                f_word_q <= f_stop_q;
                            end else begin
                                f_word_q <= sum_d[FW_W-1:0];
                            end
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
                        end
                    end
                end
                ST_BURST: begin
                    if (stop) begin
                        state_q <= ST_DRAIN;
                    end else if (phase_wrap) begin
                        if (burst_last_d) begin
                            out_en_q <= 1'b0;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            wrap_cnt_q <= wrap_cnt_q + BURST_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish the current waveform period before gating the DAC.
                    if (phase_wrap) begin
                        out_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    out_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign idle_s = (state_q == ST_IDLE);

    dds_cfg_shadow u_cfg_shadow (
        .clk             (clk),
        .rst_n           (rst_n),
        .idle_i          (idle_s),
        .phase_wrap_i    (phase_wrap),
        .cfg_valid_i     (cfg_valid),
        .cfg_wave_c_i    (cfg_wave_c),
        .cfg_amplitude_i (cfg_amplitude),
        .cfg_p_word_i    (cfg_p_word),
        .cfg_ready_o     (cfg_ready),
        .wave_c_o        (wave_c),
        .amplitude_o     (amplitude),
        .p_word_o        (p_word)
    );

    assign f_word = f_word_q;
    assign out_en = out_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
